// File: rtl/obstacle_pkg.sv
// Shared types and constants for the falling-obstacle scheduler.
package obstacle_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    SPAWN  = 2'd2
  } state_t;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int OBS_SIZE_DEF = 32;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 counted from 1 at the LSB.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Folds a 10-bit random value into [0, limit) without a divider.
  function automatic logic [9:0] fold_x(input logic [9:0] r, input logic [9:0] limit);
    return (r < limit) ? r : r - 10'd512;
  endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used as the spawn-position random source.
module obstacle_lfsr
  import obstacle_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        reset,
  output logic [15:0] value
);

  logic [15:0] lfsr_reg;
  logic        feedback;

  assign feedback = ^(lfsr_reg & LFSR_TAPS);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], feedback};
    end
  end

  assign value = lfsr_reg;

endmodule

// File: rtl/obstacle_scheduler.sv
// Per-frame obstacle slot scheduler: walks each slot down the screen, retires it at the bottom,
// and periodically spawns a new obstacle. Define OBSTACLE_TYPES_EN to store a random type per slot.
module obstacle_scheduler
  import obstacle_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int SPAWN_PERIOD = 60,
  parameter int STEP         = 4,
  parameter int OBS_SIZE     = OBS_SIZE_DEF,
  parameter int SCREEN_W     = SCREEN_W_DEF,
  parameter int SCREEN_H     = SCREEN_H_DEF
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    frame_tick,
  output logic [NUM_SLOTS-1:0]    obs_valid,
  output logic [10*NUM_SLOTS-1:0] obs_x,
  output logic [10*NUM_SLOTS-1:0] obs_y,
  output logic [2*NUM_SLOTS-1:0]  obs_type,
  output logic                    busy,
  output logic                    spawn_pulse,
  output logic                    passed_pulse
);

  localparam int               IDX_W        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_SLOTS - 1);
  localparam logic [9:0]       Y_LIMIT      = 10'(SCREEN_H - OBS_SIZE);
  localparam logic [9:0]       X_LIMIT      = 10'(SCREEN_W - OBS_SIZE);
  localparam logic [9:0]       Y_STEP       = 10'(STEP);
  localparam logic [7:0]       SPAWN_RELOAD = 8'(SPAWN_PERIOD - 1);

  state_t               state_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [7:0]           spawn_cnt_reg;
  logic [NUM_SLOTS-1:0] valid_reg;
  logic [9:0]           x_reg [NUM_SLOTS];
  logic [9:0]           y_reg [NUM_SLOTS];
  logic                 busy_reg;
  logic                 spawn_pulse_reg;
  logic                 passed_pulse_reg;

  logic [15:0]          lfsr_value;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic [9:0]           spawn_x;
  logic [9:0]           cur_y;
  logic                 spawn_now;
  logic                 unused_lfsr;

  obstacle_lfsr u_lfsr (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .value    (lfsr_value)
  );

  // Lowest-index free slot wins the allocation.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid_reg[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign spawn_x   = fold_x(lfsr_value[9:0], X_LIMIT);
  assign cur_y     = y_reg[idx_reg];
  assign spawn_now = !clear && (state_reg == SPAWN) && (spawn_cnt_reg == 8'd0) && free_found;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      idx_reg          <= '0;
      spawn_cnt_reg    <= '0;
      valid_reg        <= '0;
      busy_reg         <= 1'b0;
      spawn_pulse_reg  <= 1'b0;
      passed_pulse_reg <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_reg[i] <= '0;
        y_reg[i] <= '0;
      end
    end else begin
      spawn_pulse_reg  <= 1'b0;
      passed_pulse_reg <= 1'b0;
      if (clear) begin
        state_reg     <= IDLE;
        busy_reg      <= 1'b0;
        idx_reg       <= '0;
        spawn_cnt_reg <= '0;
        valid_reg     <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (frame_tick && enable) begin
              state_reg <= UPDATE;
              busy_reg  <= 1'b1;
              idx_reg   <= '0;
            end
          end
          UPDATE: begin
            if (valid_reg[idx_reg]) begin
              if (cur_y >= Y_LIMIT) begin
                valid_reg[idx_reg] <= 1'b0;
                passed_pulse_reg   <= 1'b1;
              end else begin
                y_reg[idx_reg] <= cur_y + Y_STEP;
              end
            end
            if (idx_reg == LAST_IDX) begin
              state_reg <= SPAWN;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
          SPAWN: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            if (spawn_cnt_reg != 8'd0) begin
              spawn_cnt_reg <= spawn_cnt_reg - 8'd1;
            end else if (free_found) begin
              valid_reg[free_idx] <= 1'b1;
              x_reg[free_idx]     <= spawn_x;
              y_reg[free_idx]     <= '0;
              spawn_pulse_reg     <= 1'b1;
              spawn_cnt_reg       <= SPAWN_RELOAD;
            end
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef OBSTACLE_TYPES_EN
  logic [1:0] type_reg [NUM_SLOTS];

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        type_reg[i] <= '0;
      end
    end else if (spawn_now) begin
      type_reg[free_idx] <= lfsr_value[11:10];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_type
      assign obs_type[2*gi +: 2] = type_reg[gi];
    end
  endgenerate

  assign unused_lfsr = ^{lfsr_value[15:12], spawn_now};
`else
  assign obs_type    = '0;
  assign unused_lfsr = ^{lfsr_value[15:10], spawn_now};
`endif

  genvar gj;
  generate
    for (gj = 0; gj < NUM_SLOTS; gj++) begin : g_slot
      assign obs_x[10*gj +: 10] = x_reg[gj];
      assign obs_y[10*gj +: 10] = y_reg[gj];
    end
  endgenerate

  assign obs_valid    = valid_reg;
  assign busy         = busy_reg;
  assign spawn_pulse  = spawn_pulse_reg;
  assign passed_pulse = passed_pulse_reg;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench: two schedulers (spawn period 60 and 1) against a frame-level reference model.
module tb_obstacle_scheduler;

  localparam int N    = 4;
  localparam int YLIM = 448;
  localparam int XLIM = 608;

  logic CLOCK_50 = 1'b0;
  logic reset, enable, clear, frame_tick;

  logic [N-1:0]    valid_o [2];
  logic [10*N-1:0] x_o     [2];
  logic [10*N-1:0] y_o     [2];
  logic [2*N-1:0]  type_o  [2];
  logic            busy_o  [2];
  logic            sp_o    [2];
  logic            pp_o    [2];

  always #5 CLOCK_50 = ~CLOCK_50;

  obstacle_scheduler dut_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .clear(clear), .frame_tick(frame_tick),
    .obs_valid(valid_o[0]), .obs_x(x_o[0]), .obs_y(y_o[0]), .obs_type(type_o[0]),
    .busy(busy_o[0]), .spawn_pulse(sp_o[0]), .passed_pulse(pp_o[0])
  );

  obstacle_scheduler #(.SPAWN_PERIOD(1)) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .clear(clear), .frame_tick(frame_tick),
    .obs_valid(valid_o[1]), .obs_x(x_o[1]), .obs_y(y_o[1]), .obs_type(type_o[1]),
    .busy(busy_o[1]), .spawn_pulse(sp_o[1]), .passed_pulse(pp_o[1])
  );

  // Random source as defined: x^16+x^14+x^13+x^11+1, seed ACE1, one step per clock.
  logic [15:0] m_lfsr, m_lfsr_prev;
  always @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      m_lfsr      <= 16'hACE1;
      m_lfsr_prev <= 16'hACE1;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  int checks = 0;
  int failures = 0;
  int m_valid [2][N];
  int m_x     [2][N];
  int m_y     [2][N];
  int m_t     [2][N];
  int m_cnt   [2];
  int period  [2];
  int frame_no = 0;
  int retire_frame = 0;
  int obs_sp [2];

  typedef struct {
    bit tick;
    bit en;
    bit exp_busy;
    bit exp_sp;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int map_x(input int r);
    return (r < XLIM) ? r : r - 512;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      for (int s = 0; s < N; s++) begin
        m_valid[k][s] = 0; m_x[k][s] = 0; m_y[k][s] = 0; m_t[k][s] = 0;
      end
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      for (int s = 0; s < N; s++) m_valid[k][s] = 0;
    end
  endtask

  task automatic model_slot(input int k, input int s, output int pp);
    pp = 0;
    if (m_valid[k][s] != 0) begin
      if (m_y[k][s] >= YLIM) begin
        m_valid[k][s] = 0;
        pp = 1;
        if (k == 0 && s == 0 && retire_frame == 0) retire_frame = frame_no + 1;
      end else begin
        m_y[k][s] += 4;
      end
    end
  endtask

  task automatic model_spawn(input int k, output int sp);
    int slot;
    sp = 0;
    slot = -1;
    if (m_cnt[k] != 0) begin
      m_cnt[k]--;
    end else begin
      for (int s = N - 1; s >= 0; s--) if (m_valid[k][s] == 0) slot = s;
      if (slot >= 0) begin
        m_valid[k][slot] = 1;
        m_y[k][slot]     = 0;
        m_x[k][slot]     = map_x(int'(m_lfsr_prev[9:0]));
`ifdef OBSTACLE_TYPES_EN
        m_t[k][slot]     = int'(m_lfsr_prev[11:10]);
`else
        m_t[k][slot]     = 0;
`endif
        m_cnt[k] = period[k] - 1;
        sp = 1;
      end
    end
  endtask

  task automatic check_ctrl(input string tag, input int eb, input int es0, input int es1,
                            input int ep0, input int ep1);
    chk({tag, " a.busy"}, int'(busy_o[0]), eb);
    chk({tag, " b.busy"}, int'(busy_o[1]), eb);
    chk({tag, " a.spawn_pulse"}, int'(sp_o[0]), es0);
    chk({tag, " b.spawn_pulse"}, int'(sp_o[1]), es1);
    chk({tag, " a.passed_pulse"}, int'(pp_o[0]), ep0);
    chk({tag, " b.passed_pulse"}, int'(pp_o[1]), ep1);
  endtask

  task automatic check_slots(input string tag);
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < N; s++) begin
        string nm;
        nm = $sformatf("%s %s.slot%0d", tag, (k == 0) ? "a" : "b", s);
        chk({nm, ".valid"}, int'(valid_o[k][s]), m_valid[k][s]);
        chk({nm, ".x"}, int'(x_o[k][10*s +: 10]), m_x[k][s]);
        chk({nm, ".y"}, int'(y_o[k][10*s +: 10]), m_y[k][s]);
        chk({nm, ".type"}, int'(type_o[k][2*s +: 2]), m_t[k][s]);
        if (valid_o[k][s]) chk({nm, ".x_in_range"}, int'(x_o[k][10*s +: 10] < 10'(XLIM)), 1);
      end
    end
  endtask

  task automatic run_frame(input int extra_at, input int clear_at, input bit drop_en);
    int pp [2];
    int sp [2];
    enable = 1'b1;
    frame_tick = 1'b1;
    @(posedge CLOCK_50); #1;
    frame_tick = 1'b0;
    check_ctrl("start", 1, 0, 0, 0, 0);
    if (drop_en) enable = 1'b0;
    for (int s = 0; s < N; s++) begin
      if (s == extra_at) frame_tick = 1'b1;
      if (s == clear_at) clear = 1'b1;
      @(posedge CLOCK_50); #1;
      frame_tick = 1'b0;
      if (clear) begin
        clear = 1'b0;
        enable = 1'b1;
        model_clear();
        check_ctrl("clear", 0, 0, 0, 0, 0);
        check_slots("clear");
        @(posedge CLOCK_50); #1;
        check_ctrl("after_clear", 0, 0, 0, 0, 0);
        $display("clear at slot %0d a_valid=%b b_valid=%b", s, valid_o[0], valid_o[1]);
        return;
      end
      for (int k = 0; k < 2; k++) model_slot(k, s, pp[k]);
      check_ctrl("update", 1, 0, 0, pp[0], pp[1]);
    end
    @(posedge CLOCK_50); #1;
    for (int k = 0; k < 2; k++) model_spawn(k, sp[k]);
    obs_sp[0] = int'(sp_o[0]);
    obs_sp[1] = int'(sp_o[1]);
    check_ctrl("spawn", 0, sp[0], sp[1], 0, 0);
    frame_no++;
    check_slots("frame");
    enable = 1'b1;
    @(posedge CLOCK_50); #1;
    check_ctrl("post_frame", 0, 0, 0, 0, 0);
    $display("frame %0d a_valid=%b b_valid=%b a_sp=%0d b_sp=%0d", frame_no, valid_o[0], valid_o[1],
             obs_sp[0], obs_sp[1]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [9];
    int   dummy;
    period[0] = 60;
    period[1] = 1;

    // Reset
    reset = 1'b0; enable = 1'b0; clear = 1'b0; frame_tick = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    model_reset();
    check_ctrl("reset", 0, 0, 0, 0, 0);
    check_slots("reset");
    reset = 1'b1;

    // First frame, cycle by cycle: disabled tick, real tick, tick while busy
    tbl[0] = '{tick: 0, en: 1, exp_busy: 0, exp_sp: 0};
    tbl[1] = '{tick: 1, en: 0, exp_busy: 0, exp_sp: 0};
    tbl[2] = '{tick: 1, en: 1, exp_busy: 1, exp_sp: 0};
    tbl[3] = '{tick: 0, en: 1, exp_busy: 1, exp_sp: 0};
    tbl[4] = '{tick: 1, en: 1, exp_busy: 1, exp_sp: 0};
    tbl[5] = '{tick: 0, en: 1, exp_busy: 1, exp_sp: 0};
    tbl[6] = '{tick: 0, en: 1, exp_busy: 1, exp_sp: 0};
    tbl[7] = '{tick: 0, en: 1, exp_busy: 0, exp_sp: 1};
    tbl[8] = '{tick: 0, en: 1, exp_busy: 0, exp_sp: 0};
    for (int i = 0; i < 9; i++) begin
      frame_tick = tbl[i].tick;
      enable     = tbl[i].en;
      @(posedge CLOCK_50); #1;
      check_ctrl($sformatf("vec%0d", i), int'(tbl[i].exp_busy), int'(tbl[i].exp_sp),
                 int'(tbl[i].exp_sp), 0, 0);
      if (tbl[i].exp_sp) begin
        model_spawn(0, dummy);
        model_spawn(1, dummy);
        frame_no = 1;
        check_slots("first_frame");
      end
      $display("vec %0d busy=%0d/%0d sp=%0d/%0d", i, busy_o[0], busy_o[1], sp_o[0], sp_o[1]);
    end
    frame_tick = 1'b0;
    enable = 1'b1;

    // Second tick two cycles into a frame must be dropped: y advances by exactly one step
    run_frame(1, -1, 1'b0);
    chk("a.slot0_y_after_extra_tick", int'(y_o[0][9:0]), 4);

    // Randomised frames with idle gaps, ignored ticks and enable dropping mid-frame
    while (frame_no < 115) begin
      int g;
      g = int'($urandom_range(0, 3));
      repeat (g) begin
        if ($urandom_range(0, 2) == 0) begin
          enable = 1'b0;
          frame_tick = 1'b1;
        end
        @(posedge CLOCK_50); #1;
        frame_tick = 1'b0;
        enable = 1'b1;
        check_ctrl("idle", 0, 0, 0, 0, 0);
      end
      run_frame(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1, -1,
                bit'($urandom_range(0, 1)));
      if (frame_no == 4) chk("b.valid_full_frame4", int'(valid_o[1]), 15);
      if (frame_no == 5) chk("b.no_spawn_frame5", obs_sp[1], 0);
      if (frame_no == 113) chk("a.slot0_y_frame113", int'(y_o[0][9:0]), 448);
      if (frame_no == 114) begin
        chk("a.slot0_valid_after_retire", int'(valid_o[0][0]), 0);
        chk("b.respawn_frame114", obs_sp[1], 1);
      end
    end
    chk("a.slot0_retire_frame", retire_frame, 114);

    // Clear while the update is at slot 2, then the very next frame spawns again
    run_frame(-1, 2, 1'b0);
    run_frame(-1, -1, 1'b0);
    chk("a.spawn_after_clear", obs_sp[0], 1);
    chk("b.spawn_after_clear", obs_sp[1], 1);

    // Asynchronous reset in the middle of an update discards the frame
    run_frame(-1, -1, 1'b0);
    enable = 1'b1;
    frame_tick = 1'b1;
    @(posedge CLOCK_50); #1;
    frame_tick = 1'b0;
    @(posedge CLOCK_50); #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_ctrl("async_reset", 0, 0, 0, 0, 0);
    check_slots("async_reset");
    @(posedge CLOCK_50); #1;
    reset = 1'b1;
    frame_no = 0;
    run_frame(-1, -1, 1'b0);
    chk("a.spawn_after_reset", obs_sp[0], 1);
    chk("b.spawn_after_reset", obs_sp[1], 1);
    run_frame(-1, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
